fht_but_sched: RTL and testbench
================================

# fht_but_sched

Address and stage sequencer for the in-place radix-2 FHT datapath. On a start strobe it walks all `N_LOG` stages of an `N = 2**N_LOG` point transform. Each cycle it issues one butterfly: three data-RAM read addresses (x0, x1, x2) and one twiddle ROM index for `fht_but`. It then issues the matching pair of write-back addresses after the read and butterfly latency. It sits between the sample RAM, the sin/cos ROM and `fht_but`, and owns the stage-to-stage read-after-write hazard.

## Interface

Parameters:
- `N_LOG`, default 10: log2 of transform length; legal range 2..12.
- `RD_LAT`, default 1: data-RAM read latency in cycles; legal range 1..3. Butterfly latency is fixed at 1.

Ports:
- `iCLK`, in, 1: single clock; all logic on the rising edge.
- `iRESET`, in, 1: synchronous, active-high reset.
- `iSTART`, in, 1: start request; sampled only in IDLE.
- `oBUSY`, out, 1: high from the first read cycle through the last write cycle.
- `oDONE`, out, 1: one-cycle pulse, the cycle after the last write.
- `oSTAGE`, out, `N_LOG`: stage index of the current read (0..`N_LOG`-1).
- `oRD_EN`, out, 1: read addresses valid this cycle.
- `oRD_ADDR_0`, `oRD_ADDR_1`, `oRD_ADDR_2`, out, `N_LOG` each: x0, x1, x2 read addresses.
- `oW_ADDR`, out, `N_LOG`-1: twiddle ROM index, aligned with the read addresses.
- `oWR_EN`, out, 1: write y0/y1 this cycle.
- `oWR_ADDR_0`, `oWR_ADDR_1`, out, `N_LOG` each: y0 and y1 write addresses.

## Operation

- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `iSTART`=1 → RUN, with stage=0, group=0, k=0.
  - `iSTART` in any other state is ignored.
- RUN issues one butterfly per cycle. With stage s, h = 2**s, base = group·2h and k in 0..h-1:
  - `oRD_ADDR_0` = base+k.
  - `oRD_ADDR_1` = base+h+k.
  - `oRD_ADDR_2` = base+h+((h−k) mod h), i.e. equal to `oRD_ADDR_1` when k=0.
  - `oW_ADDR` = k·(N/(2h)).
- Counter order: k increments first. At k=h−1 it wraps to 0 and group increments. At the last group, stage ends after N/2 butterflies → DRAIN.
- DRAIN lasts exactly `RD_LAT`+1 cycles with `oRD_EN`=0, so all writes of stage s land before any read of stage s+1.
  - At DRAIN end, if s < `N_LOG`−1 → RUN with s+1, group=0, k=0.
  - Otherwise → DONE.
- DONE lasts one cycle: `oDONE`=1, `oBUSY`=0, then → IDLE.
- Write path: `oWR_EN`, `oWR_ADDR_0` and `oWR_ADDR_1` are `oRD_EN`, `oRD_ADDR_0` and `oRD_ADDR_1` delayed by exactly `RD_LAT`+1 cycles through a shift pipeline.
- All address arithmetic is unsigned and modulo N; no address may exceed N−1.
- Reset, including mid-transform:
  - Next edge forces IDLE and clears all counters and the write pipeline.
  - All outputs become 0; no pending `oWR_EN` may emerge afterwards.
  - `iSTART` held high during reset has no effect until the first edge with `iRESET`=0.

## Timing

- All outputs are registered. Reset value of every output is 0.
- `iSTART` sampled at edge E0 → first `oRD_EN`=1 in cycle 1 (the cycle after E0).
- Per stage: N/2 RUN cycles followed by `RD_LAT`+1 DRAIN cycles, with no gap between stages.
- `oBUSY`: high for exactly `N_LOG`·(N/2+`RD_LAT`+1) cycles. The last of these cycles carries the final `oWR_EN`.
- `oDONE`: next cycle, one cycle only. `iSTART` in the `oDONE` cycle is ignored; it is accepted in the following IDLE cycle.
- `oSTAGE` holds the current read stage through RUN and DRAIN and returns to 0 in IDLE.

## Test plan

- **Stage 0 addresses**, `N_LOG`=3, `RD_LAT`=1, start at E0:
  - Cycles 1–4 read triples (0,1,1), (2,3,3), (4,5,5), (6,7,7).
  - `oW_ADDR`=0 throughout.
  - `oWR_EN` in cycles 3–6 with pairs (0,1), (2,3), (4,5), (6,7).
- **Later stages**, same run:
  - Stage 1, cycles 7–10: (0,2,2)/0, (1,3,3)/2, (4,6,6)/0, (5,7,7)/2.
  - Stage 2, cycles 13–16: (0,4,4)/0, (1,5,7)/1, (2,6,6)/2, (3,7,5)/3.
  - `oBUSY` high in cycles 1–18; `oDONE` only in cycle 19.
- **Hazard check**: with `RD_LAT`=3, no read of stage s+1 occurs in or before the cycle of the last stage-s write. Check via a scoreboard against a RAM model with 3-cycle read latency, across all stages for `N_LOG`=4.
- **Start handling**:
  - `iSTART` pulsed in mid-RUN and in the `oDONE` cycle → ignored; total length unchanged.
  - `iSTART` held high continuously → back-to-back transforms separated by one IDLE cycle.
- **Reset mid-operation**: assert `iRESET` in cycle 10 of an `N_LOG`=3 run → next cycle all outputs 0; no `oWR_EN` thereafter until a new start.
- **End to end**, `N_LOG`=10:
  - Drive `fht_but` plus RAM/ROM models from the block and compare against a real-valued reference FHT.
  - Error per bin ≤ `ACCURACY`·`N_LOG`.
  - Exactly 5120 `oWR_EN` cycles.

Source files
------------

// File: rtl/fht_but_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fht_but_sched
//  Description : Address and stage sequencer for the in-place radix-2 FHT.
//                Issues one butterfly per cycle (three read addresses plus a
//                twiddle index), replays the x0/x1 addresses as write-back
//                addresses RD_LAT+1 cycles later, and drains between stages
//                so that every write of a stage lands before the next stage
//                reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module fht_but_sched #(
   parameter int N_LOG  = 10,
   parameter int RD_LAT = 1
) (
   input  logic               iCLK,
   input  logic               iRESET,
   input  logic               iSTART,
   output logic               oBUSY,
   output logic               oDONE,
   output logic [N_LOG-1:0]   oSTAGE,
   output logic               oRD_EN,
   output logic [N_LOG-1:0]   oRD_ADDR_0,
   output logic [N_LOG-1:0]   oRD_ADDR_1,
   output logic [N_LOG-1:0]   oRD_ADDR_2,
   output logic [N_LOG-2:0]   oW_ADDR,
   output logic               oWR_EN,
   output logic [N_LOG-1:0]   oWR_ADDR_0,
   output logic [N_LOG-1:0]   oWR_ADDR_1
);

   // Butterfly counter spans N/2 values; its low s bits are k, the rest the group.
   localparam logic [N_LOG-2:0] c_last_bfly  = {(N_LOG-1){1'b1}};
   localparam logic [N_LOG-1:0] c_last_stage = N_LOG'(N_LOG - 1);
   localparam logic [N_LOG-1:0] c_one        = N_LOG'(1);
   localparam logic [1:0]       c_drain_last = 2'(RD_LAT);
   localparam int               c_pipe_w     = 2 * N_LOG + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_LOG-1:0]   r_stage;
   logic [N_LOG-1:0]   w_stage_nxt;
   logic [N_LOG-2:0]   r_bfly;
   logic [N_LOG-2:0]   w_bfly_nxt;
   logic [1:0]         r_drain;
   logic [1:0]         w_drain_nxt;

   logic [N_LOG-1:0]   w_bz;
   logic [N_LOG-1:0]   w_h;
   logic [N_LOG-1:0]   w_mask;
   logic [N_LOG-1:0]   w_k;
   logic [N_LOG-1:0]   w_base;
   logic [N_LOG-1:0]   w_a0;
   logic [N_LOG-1:0]   w_a1;
   logic [N_LOG-1:0]   w_a2;
   logic [N_LOG-2:0]   w_kt;
   logic [N_LOG-1:0]   w_wsh;
   logic [N_LOG-2:0]   w_w;
   logic               w_run_nxt;
   logic               w_busy_nxt;

   logic [c_pipe_w-1:0] r_wpipe [RD_LAT+1];

   // State and counter registers.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_state <= ST_IDLE;
         r_stage <= '0;
         r_bfly  <= '0;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_stage <= w_stage_nxt;
         r_bfly  <= w_bfly_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   // Next-state logic: k-first counting folded into one butterfly counter.
   always_comb begin
      w_state_nxt = r_state;
      w_stage_nxt = r_stage;
      w_bfly_nxt  = r_bfly;
      w_drain_nxt = r_drain;
      case (r_state)
         ST_IDLE: begin
            if (iSTART) begin
               w_state_nxt = ST_RUN;
               w_stage_nxt = '0;
               w_bfly_nxt  = '0;
            end
         end
         ST_RUN: begin
            if (r_bfly == c_last_bfly) begin
               w_state_nxt = ST_DRAIN;
               w_drain_nxt = '0;
            end else begin
               w_bfly_nxt = r_bfly + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (r_drain == c_drain_last) begin
               if (r_stage == c_last_stage) begin
                  w_state_nxt = ST_DONE;
                  w_stage_nxt = '0;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_stage_nxt = r_stage + 1'b1;
                  w_bfly_nxt  = '0;
               end
            end else begin
               w_drain_nxt = r_drain + 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Address decode for the butterfly about to be issued: a zero bit is
   // inserted at position s of the counter to form base+k.
   always_comb begin
      w_bz      = {1'b0, w_bfly_nxt};
      w_h       = c_one << w_stage_nxt;
      w_mask    = w_h - c_one;
      w_k       = w_bz & w_mask;
      w_base    = (w_bz & ~w_mask) << 1;
      w_a0      = w_base | w_k;
      w_a1      = w_a0 | w_h;
      w_a2      = w_base | w_h | ((w_h - w_k) & w_mask);
      w_kt      = w_k[N_LOG-2:0];
      w_wsh     = c_last_stage - w_stage_nxt;
      w_w       = w_kt << w_wsh;
      w_run_nxt = (w_state_nxt == ST_RUN);
      w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
   end

   // Registered read-side outputs.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oBUSY      <= 1'b0;
         oDONE      <= 1'b0;
         oSTAGE     <= '0;
         oRD_EN     <= 1'b0;
         oRD_ADDR_0 <= '0;
         oRD_ADDR_1 <= '0;
         oRD_ADDR_2 <= '0;
         oW_ADDR    <= '0;
      end else begin
         oBUSY      <= w_busy_nxt;
         oDONE      <= (w_state_nxt == ST_DONE);
         oSTAGE     <= w_busy_nxt ? w_stage_nxt : '0;
         oRD_EN     <= w_run_nxt;
         oRD_ADDR_0 <= w_run_nxt ? w_a0 : '0;
         oRD_ADDR_1 <= w_run_nxt ? w_a1 : '0;
         oRD_ADDR_2 <= w_run_nxt ? w_a2 : '0;
         oW_ADDR    <= w_run_nxt ? w_w  : '0;
      end
   end

   // Write-back pipeline: replays {rd_en, x0, x1} RD_LAT+1 cycles later.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         for (int i = 0; i <= RD_LAT; i++) begin
            r_wpipe[i] <= '0;
         end
      end else begin
         r_wpipe[0] <= {oRD_EN, oRD_ADDR_0, oRD_ADDR_1};
         for (int i = 1; i <= RD_LAT; i++) begin
            r_wpipe[i] <= r_wpipe[i-1];
         end
      end
   end

   assign oWR_EN     = r_wpipe[RD_LAT][c_pipe_w-1];
   assign oWR_ADDR_0 = r_wpipe[RD_LAT][2*N_LOG-1:N_LOG];
   assign oWR_ADDR_1 = r_wpipe[RD_LAT][N_LOG-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fht_but_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fht_but_sched
//  Description : Self-checking bench for fht_but_sched (three configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fht_but_sched;

   logic clk = 1'b0;
   logic rst;
   logic start_a, start_b, start_c;

   always #5 clk = ~clk;

   // DUT A: N_LOG=3, RD_LAT=1
   logic       a_busy, a_done, a_rd, a_wr;
   logic [2:0] a_stage, a_a0, a_a1, a_a2, a_wa0, a_wa1;
   logic [1:0] a_w;
   fht_but_sched #(.N_LOG(3), .RD_LAT(1)) u_a (
      .iCLK(clk), .iRESET(rst), .iSTART(start_a),
      .oBUSY(a_busy), .oDONE(a_done), .oSTAGE(a_stage), .oRD_EN(a_rd),
      .oRD_ADDR_0(a_a0), .oRD_ADDR_1(a_a1), .oRD_ADDR_2(a_a2), .oW_ADDR(a_w),
      .oWR_EN(a_wr), .oWR_ADDR_0(a_wa0), .oWR_ADDR_1(a_wa1));

   // DUT B: N_LOG=4, RD_LAT=3
   logic       b_busy, b_done, b_rd, b_wr;
   logic [3:0] b_stage, b_a0, b_a1, b_a2, b_wa0, b_wa1;
   logic [2:0] b_w;
   fht_but_sched #(.N_LOG(4), .RD_LAT(3)) u_b (
      .iCLK(clk), .iRESET(rst), .iSTART(start_b),
      .oBUSY(b_busy), .oDONE(b_done), .oSTAGE(b_stage), .oRD_EN(b_rd),
      .oRD_ADDR_0(b_a0), .oRD_ADDR_1(b_a1), .oRD_ADDR_2(b_a2), .oW_ADDR(b_w),
      .oWR_EN(b_wr), .oWR_ADDR_0(b_wa0), .oWR_ADDR_1(b_wa1));

   // DUT C: N_LOG=10, RD_LAT=1
   logic       c_busy, c_done, c_rd, c_wr;
   logic [9:0] c_stage, c_a0, c_a1, c_a2, c_wa0, c_wa1;
   logic [8:0] c_w;
   fht_but_sched #(.N_LOG(10), .RD_LAT(1)) u_c (
      .iCLK(clk), .iRESET(rst), .iSTART(start_c),
      .oBUSY(c_busy), .oDONE(c_done), .oSTAGE(c_stage), .oRD_EN(c_rd),
      .oRD_ADDR_0(c_a0), .oRD_ADDR_1(c_a1), .oRD_ADDR_2(c_a2), .oW_ADDR(c_w),
      .oWR_EN(c_wr), .oWR_ADDR_0(c_wa0), .oWR_ADDR_1(c_wa1));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       busy, done, rd, wr;
      logic [2:0] stg, a0, a1, a2;
      logic [1:0] w;
      logic [2:0] wa0, wa1;
   } vec_t;

   function automatic vec_t mk(int busy, int done, int rd, int wr, int stg,
                               int a0, int a1, int a2, int w, int wa0, int wa1);
      vec_t v;
      v.busy = 1'(busy); v.done = 1'(done); v.rd = 1'(rd); v.wr = 1'(wr);
      v.stg = 3'(stg); v.a0 = 3'(a0); v.a1 = 3'(a1); v.a2 = 3'(a2);
      v.w = 2'(w); v.wa0 = 3'(wa0); v.wa1 = 3'(wa1);
      return v;
   endfunction

   vec_t tbl [1:20];

   typedef struct {
      logic [3:0] a0, a1;
      int         cyc;
   } rd_rec_t;

   initial begin
      int busy_cnt, done_cnt, done_cyc, rd_cnt, wr_cnt, viol, ord_err, bad_ver, last_busy, last_wr;
      bit seen;
      int ver [16];
      rd_rec_t q_b [$];
      rd_rec_t r;
      logic [48:0] q_c [$];
      logic [48:0] e;

      //                busy done rd wr stg a0 a1 a2 w wa0 wa1
      tbl[1]  = mk(1,0,1,0,0, 0,1,1,0, 0,0);
      tbl[2]  = mk(1,0,1,0,0, 2,3,3,0, 0,0);
      tbl[3]  = mk(1,0,1,1,0, 4,5,5,0, 0,1);
      tbl[4]  = mk(1,0,1,1,0, 6,7,7,0, 2,3);
      tbl[5]  = mk(1,0,0,1,0, 0,0,0,0, 4,5);
      tbl[6]  = mk(1,0,0,1,0, 0,0,0,0, 6,7);
      tbl[7]  = mk(1,0,1,0,1, 0,2,2,0, 0,0);
      tbl[8]  = mk(1,0,1,0,1, 1,3,3,2, 0,0);
      tbl[9]  = mk(1,0,1,1,1, 4,6,6,0, 0,2);
      tbl[10] = mk(1,0,1,1,1, 5,7,7,2, 1,3);
      tbl[11] = mk(1,0,0,1,1, 0,0,0,0, 4,6);
      tbl[12] = mk(1,0,0,1,1, 0,0,0,0, 5,7);
      tbl[13] = mk(1,0,1,0,2, 0,4,4,0, 0,0);
      tbl[14] = mk(1,0,1,0,2, 1,5,7,1, 0,0);
      tbl[15] = mk(1,0,1,1,2, 2,6,6,2, 0,4);
      tbl[16] = mk(1,0,1,1,2, 3,7,5,3, 1,5);
      tbl[17] = mk(1,0,0,1,2, 0,0,0,0, 2,6);
      tbl[18] = mk(1,0,0,1,2, 0,0,0,0, 3,7);
      tbl[19] = mk(0,1,0,0,0, 0,0,0,0, 0,0);
      tbl[20] = mk(0,0,0,0,0, 0,0,0,0, 0,0);

      rst = 1'b1; start_a = 1'b1; start_b = 1'b0; start_c = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state_a", {a_busy, a_done, a_rd, a_wr, a_stage, a_a0, a_a1, a_a2, a_w, a_wa0, a_wa1}, 64'd0);
      start_a = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset_a", {a_busy, a_done, a_rd, a_wr}, 64'd0);

      // ---- table-driven full run, N_LOG=3 ----
      start_a = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) start_a = 1'b0;
         chk($sformatf("ctl_c%0d", c), {a_busy, a_done, a_rd, a_wr},
             {tbl[c].busy, tbl[c].done, tbl[c].rd, tbl[c].wr});
         if (tbl[c].busy) chk($sformatf("stage_c%0d", c), a_stage, tbl[c].stg);
         if (tbl[c].rd)
            chk($sformatf("rd_c%0d", c), {a_a0, a_a1, a_a2, a_w},
                {tbl[c].a0, tbl[c].a1, tbl[c].a2, tbl[c].w});
         if (tbl[c].wr)
            chk($sformatf("wr_c%0d", c), {a_wa0, a_wa1}, {tbl[c].wa0, tbl[c].wa1});
      end

      // ---- stray start pulses mid-RUN and in the DONE cycle ----
      busy_cnt = 0; done_cnt = 0; done_cyc = 0; rd_cnt = 0; wr_cnt = 0;
      start_a = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (a_busy) busy_cnt++;
         if (a_rd)   rd_cnt++;
         if (a_wr)   wr_cnt++;
         if (a_done) begin done_cnt++; done_cyc = c; end
         start_a = (c == 8) || (c == 19);
      end
      start_a = 1'b0;
      chk("stray_busy_len", busy_cnt, 18);
      chk("stray_done_cnt", done_cnt, 1);
      chk("stray_done_cyc", done_cyc, 19);
      chk("stray_rd_cnt", rd_cnt, 12);
      chk("stray_wr_cnt", wr_cnt, 12);

      // ---- start held high: back-to-back with one IDLE cycle ----
      start_a = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         @(negedge clk);
         if (c == 18) chk("held_busy18", {a_busy, a_done}, 2'b10);
         if (c == 19) chk("held_done19", {a_busy, a_done, a_rd}, 3'b010);
         if (c == 20) chk("held_idle20", {a_busy, a_done, a_rd, a_wr}, 4'b0000);
         if (c == 21) chk("held_restart21", {a_busy, a_rd, a_a0, a_a1, a_a2}, {2'b11, 3'd0, 3'd1, 3'd1});
      end
      start_a = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (a_done) seen = 1'b1;
      end
      chk("held_second_done", seen, 1'b1);
      @(negedge clk);

      // ---- reset in cycle 10 ----
      start_a = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) start_a = 1'b0;
      end
      rst = 1'b1; start_a = 1'b1;
      @(negedge clk);
      chk("rst_mid_outputs", {a_busy, a_done, a_rd, a_wr, a_stage, a_a0, a_a1, a_a2, a_w, a_wa0, a_wa1}, 64'd0);
      rst = 1'b0; start_a = 1'b0;
      wr_cnt = 0; busy_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (a_wr)   wr_cnt++;
         if (a_busy) busy_cnt++;
      end
      chk("rst_no_pending_wr", wr_cnt, 0);
      chk("rst_stays_idle", busy_cnt, 0);

      // ---- hazard scoreboard, N_LOG=4, RD_LAT=3 ----
      for (int i = 0; i < 16; i++) ver[i] = 0;
      viol = 0; ord_err = 0; wr_cnt = 0; busy_cnt = 0; last_busy = 0; last_wr = 0;
      seen = 1'b0;
      start_b = 1'b1;
      for (int c = 1; c <= 200 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) start_b = 1'b0;
         if (b_busy) begin busy_cnt++; last_busy = c; end
         if (b_rd) begin
            if (ver[b_a0] != int'(b_stage)) viol++;
            if (ver[b_a1] != int'(b_stage)) viol++;
            if (ver[b_a2] <  int'(b_stage)) viol++;
            r.a0 = b_a0; r.a1 = b_a1; r.cyc = c;
            q_b.push_back(r);
         end
         if (b_wr) begin
            wr_cnt++; last_wr = c;
            if (q_b.size() == 0) ord_err++;
            else begin
               r = q_b.pop_front();
               if (r.a0 != b_wa0 || r.a1 != b_wa1 || r.cyc + 4 != c) ord_err++;
            end
            ver[b_wa0]++;
            ver[b_wa1]++;
         end
         if (b_done) seen = 1'b1;
      end
      bad_ver = 0;
      for (int i = 0; i < 16; i++) if (ver[i] != 4) bad_ver++;
      chk("b_done_seen", seen, 1'b1);
      chk("b_hazard_violations", viol, 0);
      chk("b_write_order_errors", ord_err, 0);
      chk("b_write_count", wr_cnt, 32);
      chk("b_busy_len", busy_cnt, 48);
      chk("b_last_wr_in_last_busy", last_wr, last_busy);
      chk("b_addr_coverage", bad_ver, 0);

      // ---- N_LOG=10 full sequence against nested-loop reference ----
      for (int s = 0; s < 10; s++) begin
         int h;
         h = 1 << s;
         for (int g = 0; g < (512 >> s); g++)
            for (int k = 0; k < h; k++) begin
               int base;
               base = g * 2 * h;
               e = {10'(s), 10'(base + k), 10'(base + h + k),
                    10'(base + h + ((h - k) % h)), 9'(k * (512 / h))};
               q_c.push_back(e);
            end
      end
      ord_err = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; rd_cnt = 0;
      seen = 1'b0;
      start_c = 1'b1;
      for (int c = 1; c <= 6000 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) start_c = 1'b0;
         if (c_busy) busy_cnt++;
         if (c_wr)   wr_cnt++;
         if (c_rd) begin
            rd_cnt++;
            if (q_c.size() == 0) ord_err++;
            else begin
               e = q_c.pop_front();
               if (e != {c_stage, c_a0, c_a1, c_a2, c_w}) ord_err++;
            end
         end
         if (c_done) begin done_cnt++; seen = 1'b1; end
      end
      @(negedge clk);
      if (c_done) done_cnt++;
      chk("c_done_seen", seen, 1'b1);
      chk("c_addr_sequence_errors", ord_err, 0);
      chk("c_read_count", rd_cnt, 5120);
      chk("c_write_count", wr_cnt, 5120);
      chk("c_busy_len", busy_cnt, 5140);
      chk("c_done_single", done_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
